// File: rtl/daq_arbiter_pkg.sv
// Shared types and constants for the DAQ record arbiter.
// Header layout is {magic, source index, payload length}.
package daq_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_COPY,
        ST_DISCARD,
        ST_COMMIT
    } arb_state_t;

    localparam logic [7:0] HEADER_MAGIC  = 8'hD7;
    localparam int         HDR_MAGIC_LSB = 24;
    localparam int         HDR_SRC_LSB   = 16;
    localparam int         HDR_LEN_LSB   = 0;

    function automatic logic [31:0] make_header(input logic [7:0] src, input logic [15:0] len);
        logic [31:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 8] = HEADER_MAGIC;
        h[HDR_SRC_LSB +: 8]   = src;
        h[HDR_LEN_LSB +: 16]  = len;
        return h;
    endfunction

endpackage

// File: rtl/daq_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [2:0]      ptr,
    output logic            found,
    output logic [2:0]      index
);

    logic [2*NREQ-1:0] doubled;
    logic [NREQ-1:0]   rotated;
    logic [3:0]        sum;

    always_comb begin
        found   = 1'b0;
        sum     = '0;
        doubled = {eligible, eligible};
        rotated = NREQ'(doubled >> ptr);
        // Descending scan so the smallest offset from ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + 4'(k);
            end
        end
        index = (sum >= 4'(NREQ)) ? 3'(sum - 4'(NREQ)) : sum[2:0];
    end

endmodule

// File: rtl/daq_arbiter.sv
// Round-robin merge of FWFT record producers into one length/data FIFO pair;
// the length word is committed only after all of the record's data words.
module daq_arbiter
    import daq_arbiter_pkg::*;
#(
    parameter int NREQ            = 4,
    parameter int MAC_PACKET_BITS = 9,
    parameter int MAX_RECORD      = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               enable_mask,
    input  logic [NREQ*MAC_PACKET_BITS-1:0] req_len,
    input  logic [NREQ-1:0]               req_len_valid,
    output logic [NREQ-1:0]               req_len_rd_en,
    input  logic [NREQ*32-1:0]            req_data,
    output logic [NREQ-1:0]               req_data_rd_en,
    output logic [31:0]                   out_data,
    output logic                          out_data_wr_en,
    input  logic                          out_data_full,
    output logic [MAC_PACKET_BITS-1:0]    out_len,
    output logic                          out_len_wr_en,
    input  logic                          out_len_full,
    output logic                          busy,
    output logic [2:0]                    grant,
    output logic [7:0]                    drop_count
);

    localparam int              W       = MAC_PACKET_BITS;
    localparam logic [W-1:0]    MAX_LEN = W'(MAX_RECORD);

    // Handshake: a producer head (req_len/req_data) is consumed on every cycle its
    // rd_en is high; rd_en is only raised when the matching head is known valid and
    // the downstream FIFO is not full, so a full flag stalls without popping.
    arb_state_t      state, state_next;
    logic [2:0]      grant_r, rr_ptr, pick_idx;
    logic [W-1:0]    remaining, len_r, pick_len;
    logic [NREQ-1:0] eligible;
    logic [31:0]     cur_data, data_word;
    logic            pick_found, load, decr, data_pop, len_pop;
    logic            wr_data, wr_len, advance_ptr, drop;

    assign eligible = req_len_valid & enable_mask;
    assign pick_len = req_len[pick_idx*W +: W];
    assign cur_data = req_data[grant_r*32 +: 32];

    rr_pick #(.NREQ(NREQ)) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .found    (pick_found),
        .index    (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        decr        = 1'b0;
        data_pop    = 1'b0;
        len_pop     = 1'b0;
        wr_data     = 1'b0;
        wr_len      = 1'b0;
        advance_ptr = 1'b0;
        drop        = 1'b0;
        data_word   = '0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    load       = 1'b1;
                    state_next = (pick_len > MAX_LEN) ? ST_DISCARD : ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (!out_data_full) begin
                    wr_data    = 1'b1;
                    data_word  = make_header(8'(grant_r), 16'(len_r));
                    state_next = (len_r == '0) ? ST_COMMIT : ST_COPY;
                end
            end
            ST_COPY: begin
                if (!out_data_full) begin
                    data_pop  = 1'b1;
                    wr_data   = 1'b1;
                    data_word = cur_data;
                    decr      = 1'b1;
                    if (remaining == W'(1)) state_next = ST_COMMIT;
                end
            end
            ST_DISCARD: begin
                // Oversized records are consumed silently, then the length is popped.
                if (remaining != '0) begin
                    data_pop = 1'b1;
                    decr     = 1'b1;
                end else begin
                    len_pop     = 1'b1;
                    drop        = 1'b1;
                    advance_ptr = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (!out_len_full) begin
                    wr_len      = 1'b1;
                    len_pop     = 1'b1;
                    advance_ptr = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign req_data_rd_en = data_pop ? (NREQ'(1) << grant_r) : '0;
    assign req_len_rd_en  = len_pop  ? (NREQ'(1) << grant_r) : '0;
    assign busy           = (state != ST_IDLE);
    assign grant          = grant_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data       <= '0;
            out_data_wr_en <= 1'b0;
            out_len        <= '0;
            out_len_wr_en  <= 1'b0;
            grant_r        <= '0;
            rr_ptr         <= '0;
            remaining      <= '0;
            len_r          <= '0;
            drop_count     <= '0;
        end else begin
            out_data_wr_en <= wr_data;
            out_len_wr_en  <= wr_len;
            if (wr_data) out_data <= data_word;
            if (wr_len)  out_len  <= len_r + W'(1);
            if (load) begin
                grant_r   <= pick_idx;
                remaining <= pick_len;
                len_r     <= pick_len;
            end else if (decr) begin
                remaining <= remaining - W'(1);
            end
            if (advance_ptr) rr_ptr <= (grant_r == 3'(NREQ - 1)) ? 3'd0 : grant_r + 3'd1;
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_daq_arbiter.sv
// Directed bench for daq_arbiter: FWFT producer model, output monitor and
// expected queues for data words, length words and grant order.
module tb_daq_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 9;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     enable_mask;
    logic [NREQ*W-1:0]   req_len;
    logic [NREQ-1:0]     req_len_valid;
    logic [NREQ-1:0]     req_len_rd_en;
    logic [NREQ*32-1:0]  req_data;
    logic [NREQ-1:0]     req_data_rd_en;
    logic [31:0]         out_data;
    logic                out_data_wr_en;
    logic                out_data_full;
    logic [W-1:0]        out_len;
    logic                out_len_wr_en;
    logic                out_len_full;
    logic                busy;
    logic [2:0]          grant;
    logic [7:0]          drop_count;

    daq_arbiter #(.NREQ(NREQ), .MAC_PACKET_BITS(W), .MAX_RECORD(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_mask    (enable_mask),
        .req_len        (req_len),
        .req_len_valid  (req_len_valid),
        .req_len_rd_en  (req_len_rd_en),
        .req_data       (req_data),
        .req_data_rd_en (req_data_rd_en),
        .out_data       (out_data),
        .out_data_wr_en (out_data_wr_en),
        .out_data_full  (out_data_full),
        .out_len        (out_len),
        .out_len_wr_en  (out_len_wr_en),
        .out_len_full   (out_len_full),
        .busy           (busy),
        .grant          (grant),
        .drop_count     (drop_count)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Producer storage: per-requester data and length rings
    logic [31:0]  dmem [NREQ][256];
    logic [W-1:0] lmem [NREQ][16];
    logic [7:0]   drd [NREQ];
    logic [7:0]   dwr [NREQ];
    logic [3:0]   lrd [NREQ];
    logic [3:0]   lwr [NREQ];
    int           data_pops [NREQ];
    int           len_pops [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_len[i*W +: W]     = lmem[i][lrd[i]];
            req_len_valid[i]      = (lrd[i] != lwr[i]);
            req_data[i*32 +: 32]  = dmem[i][drd[i]];
        end
    end

    // Scoreboard queues
    logic [31:0] exp_q[$];
    logic [31:0] exp_len_q[$];
    logic [31:0] exp_grant_q[$];
    logic [31:0] obs_d[$];
    logic [31:0] obs_l[$];
    logic [31:0] obs_g[$];
    int          obs_lat[$];
    int          n_checks;
    int          n_fail;

    // Pops are sampled mid-cycle (rd_en is stable) and applied just after the edge.
    initial begin
        logic [NREQ-1:0] pd, pl;
        forever begin
            @(negedge clk);
            pd = req_data_rd_en;
            pl = req_len_rd_en;
            for (int i = 0; i < NREQ; i++) begin
                data_pops[i] += int'(pd[i]);
                len_pops[i]  += int'(pl[i]);
            end
            if (out_data_wr_en) obs_d.push_back(out_data);
            if (out_len_wr_en) begin
                obs_l.push_back(32'(out_len));
                obs_g.push_back(32'(grant));
                obs_lat.push_back(obs_d.size());
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (pd[i]) drd[i] = drd[i] + 8'd1;
                if (pl[i]) lrd[i] = lrd[i] + 4'd1;
            end
        end
    end

    // Driver tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_rec(input int r, input int len, input logic [31:0] base, input bit fwd);
        if (fwd) begin
            exp_q.push_back({8'hD7, 8'(r), 16'(len)});
            exp_len_q.push_back(32'(len + 1));
            exp_grant_q.push_back(32'(r));
        end
        for (int k = 0; k < len; k++) begin
            dmem[r][dwr[r]] = base + 32'(k);
            dwr[r] = dwr[r] + 8'd1;
            if (fwd) exp_q.push_back(base + 32'(k));
        end
        lmem[r][lwr[r]] = W'(len);
        lwr[r] = lwr[r] + 4'd1;
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        bit timed_out;
        cyc = 0;
        @(negedge clk);
        while ((busy || (req_len_valid & enable_mask) != '0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        timed_out = (cyc >= 2000);
        check({tag, " timeout"}, 32'(timed_out), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_words(input string tag, input int n);
        int cyc;
        bit timed_out;
        cyc = 0;
        while (obs_d.size() < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        timed_out = (cyc >= 500);
        check({tag, " wait"}, 32'(timed_out), 32'd0);
    endtask

    task automatic compare(input string tag);
        check({tag, " data count"}, 32'(obs_d.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_d.size() && i < exp_q.size(); i++)
            check($sformatf("%s data[%0d]", tag, i), obs_d[i], exp_q[i]);
        check({tag, " len count"}, 32'(obs_l.size()), 32'(exp_len_q.size()));
        for (int i = 0; i < obs_l.size() && i < exp_len_q.size(); i++)
            check($sformatf("%s len[%0d]", tag, i), obs_l[i], exp_len_q[i]);
        for (int i = 0; i < obs_g.size() && i < exp_grant_q.size(); i++)
            check($sformatf("%s grant[%0d]", tag, i), obs_g[i], exp_grant_q[i]);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        exp_len_q.delete();
        exp_grant_q.delete();
        obs_d.delete();
        obs_l.delete();
        obs_g.delete();
        obs_lat.delete();
    endtask

    task automatic clear_producers();
        for (int i = 0; i < NREQ; i++) begin
            drd[i] = '0;
            dwr[i] = '0;
            lrd[i] = '0;
            lwr[i] = '0;
        end
    endtask

    // Directed sequence
    initial begin
        int cyc;
        int dp, lp;
        n_checks = 0;
        n_fail   = 0;
        rst           = 1'b1;
        enable_mask   = '1;
        out_data_full = 1'b0;
        out_len_full  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            data_pops[i] = 0;
            len_pops[i]  = 0;
            for (int k = 0; k < 256; k++) dmem[i][k] = '0;
            for (int k = 0; k < 16; k++) lmem[i][k] = '0;
        end
        clear_producers();

        repeat (2) @(negedge clk);
        check("reset out_data", out_data, 32'h0);
        check("reset data_wr", 32'(out_data_wr_en), 32'h0);
        check("reset out_len", 32'(out_len), 32'h0);
        check("reset len_wr", 32'(out_len_wr_en), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset grant", 32'(grant), 32'h0);
        check("reset drop", 32'(drop_count), 32'h0);
        check("reset rd_en", 32'({req_data_rd_en, req_len_rd_en}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single record on req0, len 3: n+3 cycles to the length write
        dp = data_pops[0];
        lp = len_pops[0];
        push_rec(0, 3, 32'h0A0A_0000, 1'b1);
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (out_len_wr_en) break;
        end
        check("single latency", 32'(cyc), 32'd6);
        wait_idle("single");
        compare("single");
        if (obs_d.size() > 0) check("single header", obs_d[0], 32'hD700_0003);
        check("single data pops", 32'(data_pops[0] - dp), 32'd3);
        check("single len pops", 32'(len_pops[0] - lp), 32'd1);
        check("single busy", 32'(busy), 32'd0);
        clear_sb();

        // Zero-length record on req3
        dp = data_pops[3];
        push_rec(3, 0, 32'h0, 1'b1);
        wait_idle("zero");
        compare("zero");
        if (obs_d.size() > 0) check("zero header", obs_d[0], 32'hD703_0000);
        if (obs_l.size() > 0) check("zero out_len", obs_l[0], 32'd1);
        check("zero data pops", 32'(data_pops[3] - dp), 32'd0);
        clear_sb();

        // Fairness: three requesters with two len-1 records each
        push_rec(0, 1, 32'h1000_0000, 1'b1);
        push_rec(1, 1, 32'h1100_0000, 1'b1);
        push_rec(2, 1, 32'h1200_0000, 1'b1);
        push_rec(0, 1, 32'h1000_0001, 1'b1);
        push_rec(1, 1, 32'h1100_0001, 1'b1);
        push_rec(2, 1, 32'h1200_0001, 1'b1);
        wait_idle("fair");
        compare("fair");
        check("fair grant count", 32'(obs_g.size()), 32'd6);
        clear_sb();

        // Back-pressure: out_data_full for 5 cycles in the middle of COPY
        push_rec(2, 6, 32'hB000_0000, 1'b1);
        wait_words("bp", 3);
        @(posedge clk);
        #2 out_data_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp hold rd_en[%0d]", i), 32'(req_data_rd_en), 32'd0);
            @(posedge clk);
            #2;
            check($sformatf("bp hold wr[%0d]", i), 32'({out_data_wr_en, out_len_wr_en}), 32'd0);
        end
        out_data_full = 1'b0;
        wait_idle("bp");
        compare("bp");
        if (obs_lat.size() > 0) check("bp len after data", 32'(obs_lat[0]), 32'd7);
        clear_sb();

        // Oversized record on req1 is drained; req2 then served normally
        dp = data_pops[1];
        lp = len_pops[1];
        push_rec(1, 65, 32'hC000_0000, 1'b0);
        push_rec(2, 2, 32'hD000_0000, 1'b1);
        wait_idle("drop");
        compare("drop");
        check("drop count", 32'(drop_count), 32'd1);
        check("drop data pops", 32'(data_pops[1] - dp), 32'd65);
        check("drop len pops", 32'(len_pops[1] - lp), 32'd1);
        clear_sb();

        // Reset in the middle of COPY
        push_rec(2, 8, 32'hE000_0000, 1'b0);
        wait_words("rst", 3);
        rst = 1'b1;
        #1;
        check("rst out_data", out_data, 32'h0);
        check("rst strobes", 32'({out_data_wr_en, out_len_wr_en}), 32'h0);
        check("rst out_len", 32'(out_len), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst grant", 32'(grant), 32'h0);
        check("rst drop", 32'(drop_count), 32'h0);
        check("rst rd_en", 32'({req_data_rd_en, req_len_rd_en}), 32'h0);
        @(negedge clk);
        clear_producers();
        clear_sb();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_rec(0, 2, 32'hF000_0000, 1'b1);
        push_rec(2, 1, 32'hF200_0000, 1'b1);
        wait_idle("post rst");
        compare("post rst");
        check("post rst grant count", 32'(obs_g.size()), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/daq_arbiter.md
# daq_arbiter

Round-robin arbiter that merges up to NREQ independent DAQ record producers into the single length/data FIFO pair that feeds the Ethernet MAC packetizer. Each producer exposes a first-word-fall-through (FWFT) length queue and data queue. The arbiter moves one whole record at a time, prepends a 32-bit source header and commits the length word only after all data words are written. This guarantees the MAC never sees a length before its data is complete. Oversized records are drained and counted, never forwarded.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- MAC_PACKET_BITS, 9: width of length words, ≤16.
- MAX_RECORD, 64: largest forwarded payload in words. Must be ≤ 2^MAC_PACKET_BITS−2.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- enable_mask  in  NREQ  a requester is eligible only when its bit is 1.
- req_len  in  NREQ*MAC_PACKET_BITS  per-requester FWFT length head; slice i is requester i.
- req_len_valid  in  NREQ  length queue i non-empty.
- req_len_rd_en  out  NREQ  combinational pop of length head.
- req_data  in  NREQ*32  per-requester FWFT data head.
- req_data_rd_en  out  NREQ  combinational pop of data head.
- out_data  out  32  word to MAC data FIFO.
- out_data_wr_en  out  1  write strobe.
- out_data_full  in  1  programmable-full with ≥2 words slack.
- out_len  out  MAC_PACKET_BITS  record length to MAC length FIFO (payload+1).
- out_len_wr_en  out  1  write strobe.
- out_len_full  in  1  programmable-full with ≥2 entries slack.
- busy  out  1  state ≠ IDLE.
- grant  out  3  index of current or last granted requester.
- drop_count  out  8  saturating count of discarded oversized records.

## Operation
- Producers write all data words before pushing the length, so req_data is valid for the whole record once req_len_valid is high.
- States: IDLE, HEADER, COPY, DISCARD, COMMIT.
- IDLE: a requester is eligible when req_len_valid & enable_mask. Pick the first eligible index at or after rr_ptr, wrapping. Latch grant and remaining = req_len[g], then:
  - if req_len[g] > MAX_RECORD → DISCARD;
  - else → HEADER.
- HEADER: when !out_data_full, write header {8'hD7, 8'(g), 16'(len)} → COPY, or → COMMIT if len==0.
- COPY: in each cycle with !out_data_full, assert req_data_rd_en[g], write req_data[g] and decrement remaining. On the last word → COMMIT.
- DISCARD: assert req_data_rd_en[g] every cycle, with no output writes, until remaining reaches 0. Then assert req_len_rd_en[g], increment drop_count (saturating at 255), set rr_ptr = g+1 mod NREQ → IDLE.
  - A zero remaining count is impossible here because len > MAX_RECORD ≥ 0.
- COMMIT: when !out_len_full, write out_len = len+1, assert req_len_rd_en[g], set rr_ptr = g+1 mod NREQ → IDLE.
- enable_mask is sampled only in IDLE. Clearing a bit mid-record does not abort that record.

## Timing
- Reset value of every output is 0, with all strobes low. State resets to IDLE, rr_ptr to 0, drop_count to 0.
- out_data, out_len and the write strobes are registered: each appears one cycle after the deciding edge. The rd_en outputs are combinational from state and full flags.
- Latency: len_valid seen in IDLE at edge 0, header written at edge 1 (visible cycle 2), first payload word visible cycle 3.
- Throughput: a record of n words takes n+3 cycles without back-pressure (IDLE, HEADER, n×COPY, COMMIT).
- A full flag stalls in place. Nothing is popped or written while stalled.
- Simultaneous requests are resolved by the rr_ptr rotation. A lone requester is granted every round.
- Reset mid-record aborts immediately. Downstream FIFOs must be reset together with the arbiter; the arbiter makes no recovery attempt.

## Structure
- Package daq_arbiter_pkg holds the state enum, HEADER_MAGIC = 8'hD7 and the header field positions.
- One sub-module, rr_pick: combinational round-robin picker taking (eligible[NREQ], ptr) and returning (found, index).

## Test plan
- Single record: req0 with len 3 and words A,B,C → out_data D7000003, A, B, C; then out_len 4; one req_len_rd_en pulse; busy falls.
- Fairness: req0, req1 and req2 each hold two len-1 records → grant order 0,1,2,0,1,2.
- Back-pressure: out_data_full held for 5 cycles mid-COPY → no pops or writes during the hold; data order intact; out_len written last.
- Zero-length record: len 0 on req3 → header D7030000, out_len 1, no data pops.
- Oversized record: len MAX_RECORD+1 on req1 → MAX_RECORD+1 data pops, no output writes, drop_count 1; the next requester is then served normally.
- Reset mid-COPY: assert rst → all outputs 0 in the same cycle; after release, a new record is forwarded correctly and grant starts from index 0.
